// File: rtl/fb_rect_writer_pkg.sv
// Shared definitions for the frame-buffer rectangle fill engine.
// Frame geometry, colour field layout and FSM state encoding.
package fb_rect_writer_pkg;

  localparam int COL_BITS     = 7;
  localparam int ROW_BITS     = 7;
  localparam int COLOR_BITS   = 12;
  localparam int FB_ADDR_BITS = COL_BITS + ROW_BITS;

  localparam int FIELD_BITS = 4;
  localparam logic [3:0] RED_LSB   = 4'd8;
  localparam logic [3:0] GREEN_LSB = 4'd4;
  localparam logic [3:0] BLUE_LSB  = 4'd0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    FILL = ST_FILL,
    DONE = ST_DONE
  } state_t;

  function automatic logic [FIELD_BITS-1:0] color_field(
    input logic [COLOR_BITS-1:0] c,
    input logic [3:0]            lsb
  );
    return c[lsb +: FIELD_BITS];
  endfunction

endpackage

// File: rtl/fb_raster_counter.sv
// Raster-order col/row walker over a loaded rectangle [xl..xh]x[yl..yh].
// Ports: clk, reset, load + bounds, adv, col/row position, last-pixel flag.
module fb_raster_counter
  import fb_rect_writer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                adv,
  input  logic [COL_BITS-1:0] xl,
  input  logic [COL_BITS-1:0] xh,
  input  logic [ROW_BITS-1:0] yl,
  input  logic [ROW_BITS-1:0] yh,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row,
  output logic                last
);

  logic [COL_BITS-1:0] xl_q;
  logic [COL_BITS-1:0] xh_q;
  logic [ROW_BITS-1:0] yh_q;

  assign last = (col == xh_q) && (row == yh_q);

  // Holding at the last pixel keeps a full-frame walk from wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      col  <= '0;
      row  <= '0;
      xl_q <= '0;
      xh_q <= '0;
      yh_q <= '0;
    end else if (load) begin
      col  <= xl;
      row  <= yl;
      xl_q <= xl;
      xh_q <= xh;
      yh_q <= yh;
    end else if (adv && !last) begin
      if (col == xh_q) begin
        col <= xl_q;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Solid-colour rectangle fill into the 128x128 frame memory.
// Ports: start/x0/y0/x1/y1/color command, wr_* memory port, busy/done.
module fb_rect_writer
  import fb_rect_writer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [COL_BITS-1:0]     x0,
  input  logic [ROW_BITS-1:0]     y0,
  input  logic [COL_BITS-1:0]     x1,
  input  logic [ROW_BITS-1:0]     y1,
  input  logic [COLOR_BITS-1:0]   color,
  input  logic                    wr_grant,
  output logic                    wr_en,
  output logic [FB_ADDR_BITS-1:0] wr_address,
  output logic [COLOR_BITS-1:0]   wr_data,
  output logic                    busy,
  output logic                    done
);

  state_t state;

  logic [COL_BITS-1:0] xl;
  logic [COL_BITS-1:0] xh;
  logic [ROW_BITS-1:0] yl;
  logic [ROW_BITS-1:0] yh;
  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;
  logic                last;
  logic                load;
  logic                adv;

  assign xl = (x0 < x1) ? x0 : x1;
  assign xh = (x0 < x1) ? x1 : x0;
  assign yl = (y0 < y1) ? y0 : y1;
  assign yh = (y0 < y1) ? y1 : y0;

  assign load = (state == IDLE) && start;
  assign adv  = (state == FILL) && wr_grant;

  fb_raster_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .adv   (adv),
    .xl    (xl),
    .xh    (xh),
    .yl    (yl),
    .yh    (yh),
    .col   (col),
    .row   (row),
    .last  (last)
  );

  // col/row are flops, so the address is register-driven.
  assign wr_address = {row, col};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            wr_data <= color;
            wr_en   <= 1'b1;
            busy    <= 1'b1;
            state   <= FILL;
          end
        end
        FILL: begin
          if (wr_grant && last) begin
            wr_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          wr_en <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Scoreboard bench for fb_rect_writer.
// Expected writes are queued at command time and popped per granted write.
module tb_fb_rect_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  x0, y0, x1, y1;
  logic [11:0] color;
  logic        wr_grant;
  logic        wr_en;
  logic [13:0] wr_address;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;

  fb_rect_writer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .color      (color),
    .wr_grant   (wr_grant),
    .wr_en      (wr_en),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [25:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rect(input int ax0, input int ay0, input int ax1,
                           input int ay1, input logic [11:0] c);
    int lx, hx, ly, hy;
    lx = (ax0 < ax1) ? ax0 : ax1;
    hx = (ax0 < ax1) ? ax1 : ax0;
    ly = (ay0 < ay1) ? ay0 : ay1;
    hy = (ay0 < ay1) ? ay1 : ay0;
    for (int r = ly; r <= hy; r++)
      for (int k = lx; k <= hx; k++)
        sb.push_back({14'(r * 128 + k), c});
  endtask

  task automatic go(input int ax0, input int ay0, input int ax1,
                    input int ay1, input logic [11:0] c);
    x0 = 7'(ax0);
    y0 = 7'(ay0);
    x1 = 7'(ax1);
    y1 = 7'(ay1);
    color = c;
    start = 1'b1;
    step();
    start = 1'b0;
    x0 = 7'($urandom);
    y0 = 7'($urandom);
    x1 = 7'($urandom);
    y1 = 7'($urandom);
    color = 12'($urandom);
  endtask

  task automatic wait_done(input string tag, input int base,
                           input int budget);
    int n;
    n = 0;
    while (done_cnt == base && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != base), 1);
  endtask

  task automatic close_test(input string tag, input int bd,
                            input int bw, input int nw);
    step();
    step();
    chk({tag, "_writes"}, wr_cnt - bw, nw);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_one_done"}, done_cnt - bd, 1);
  endtask

  int bd, bw, s;
  bit seq[5];
  int ea[5];

  initial begin
    fork
      forever begin
        logic [25:0] e;
        @(negedge clk);
        if (wr_en === 1'b1 && wr_grant === 1'b1) begin
          wr_cnt++;
          if (sb.size() == 0) begin
            chk("extra_wr", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", 32'(wr_address), 32'(e[25:12]));
            chk("wr_data", 32'(wr_data), 32'(e[11:0]));
          end
        end
        if (done === 1'b1) begin
          done_cnt++;
          done_cyc = cyc;
          chk("busy_at_done", 32'(busy), 0);
          chk("wr_en_at_done", 32'(wr_en), 0);
        end
      end
    join_none

    reset = 1'b1;
    start = 1'b0;
    wr_grant = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    color = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(wr_address), 0);
    chk("rst_data", 32'(wr_data), 0);

    // reset beats a simultaneous start
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    step();
    chk("rst_start_wr_en", 32'(wr_en), 0);
    chk("rst_start_busy", 32'(busy), 0);

    // full-frame clear
    bd = done_cnt; bw = wr_cnt;
    push_rect(0, 0, 127, 127, 12'h000);
    go(0, 0, 127, 127, 12'h000);
    s = cyc;
    chk("ff_first_wr_en", 32'(wr_en), 1);
    chk("ff_first_busy", 32'(busy), 1);
    chk("ff_first_addr", 32'(wr_address), 0);
    wait_done("ff", bd, 17000);
    chk("ff_done_lat", done_cyc - s, 16384);
    close_test("ff", bd, bw, 16384);

    // swapped corners
    bd = done_cnt; bw = wr_cnt;
    push_rect(10, 5, 8, 3, 12'hF80);
    go(10, 5, 8, 3, 12'hF80);
    chk("sw_first_addr", 32'(wr_address), 392);
    wait_done("sw", bd, 100);
    close_test("sw", bd, bw, 9);

    // arbitration stall on a 2x1 rect
    seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ea = '{0, 0, 1, 1, 1};
    bd = done_cnt; bw = wr_cnt;
    push_rect(0, 0, 1, 0, 12'h5A5);
    wr_grant = 1'b0;
    go(0, 0, 1, 0, 12'h5A5);
    for (int i = 0; i < 5; i++) begin
      wr_grant = seq[i];
      chk("st_addr", 32'(wr_address), 32'(ea[i]));
      chk("st_wr_en", 32'(wr_en), 1);
      step();
    end
    chk("st_done", 32'(done), 1);
    wr_grant = 1'b1;
    close_test("st", bd, bw, 2);

    // single pixel at the far corner
    bd = done_cnt; bw = wr_cnt;
    push_rect(127, 127, 127, 127, 12'h0F0);
    go(127, 127, 127, 127, 12'h0F0);
    wait_done("sp", bd, 20);
    close_test("sp", bd, bw, 1);

    // reset after 5 writes of a 4x4 fill
    bd = done_cnt; bw = wr_cnt;
    for (int i = 0; i < 5; i++)
      sb.push_back({7'(i / 4), 7'(i % 4), 12'hABC});
    go(0, 0, 3, 3, 12'hABC);
    repeat (5) step();
    reset = 1'b1;
    wr_grant = 1'b0;
    step();
    reset = 1'b0;
    wr_grant = 1'b1;
    chk("rm_wr_en", 32'(wr_en), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_done", 32'(done), 0);
    repeat (4) step();
    chk("rm_no_done", done_cnt - bd, 0);
    chk("rm_writes", wr_cnt - bw, 5);
    chk("rm_sb_empty", sb.size(), 0);
    bd = done_cnt; bw = wr_cnt;
    push_rect(1, 1, 1, 1, 12'h321);
    go(1, 1, 1, 1, 12'h321);
    chk("rm_new_addr", 32'(wr_address), 129);
    wait_done("rm2", bd, 20);
    close_test("rm2", bd, bw, 1);

    // start while busy is ignored
    bd = done_cnt; bw = wr_cnt;
    push_rect(2, 2, 4, 3, 12'h123);
    go(2, 2, 4, 3, 12'h123);
    step();
    x0 = 7'd50; y0 = 7'd50; x1 = 7'd60; y1 = 7'd60;
    color = 12'hFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("sb", bd, 50);
    close_test("sb", bd, bw, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
